// File: rtl/la_ioanalog_arb_pkg.sv
// Shared types and helpers for the analog pad arbiter.
//   state_t  : sequencer states IDLE -> BREAK -> MAKE -> ACTIVE
//   PATH_*   : encodings of the per-requester path select
//   onehot3  : path select -> one-hot switch enable (reserved path -> all off)
package la_ioanalog_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    MAKE   = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam logic [1:0] PATH_DIRECT = 2'd0;
  localparam logic [1:0] PATH_SMALLR = 2'd1;
  localparam logic [1:0] PATH_BIGR   = 2'd2;
  localparam logic [1:0] PATH_RSVD   = 2'd3;

  function automatic logic [2:0] onehot3(input logic [1:0] path);
    logic [2:0] sw;
    case (path)
      PATH_DIRECT: sw = 3'b001;
      PATH_SMALLR: sw = 3'b010;
      PATH_BIGR:   sw = 3'b100;
      PATH_RSVD:   sw = 3'b000;
      default:     sw = 3'b000;
    endcase
    return sw;
  endfunction

endpackage

// File: rtl/la_ioanalog_arb_rrarb.sv
// Module: la_rrarb
// Round-robin picker: selects the first asserted request at or after ptr,
// wrapping around to index 0.  Purely combinational.
//   req     in  N   request vector
//   ptr     in  PW  round-robin start index
//   gnt     out N   one-hot winner (0 when no request)
//   gnt_idx out PW  binary index of the winner
//   any     out 1   at least one request present
module la_rrarb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (PW'(gi) >= ptr);
    end
  endgenerate

  assign hi_req = req & hi_mask;
  assign any    = |req;

  // Downward scans leave the lowest set index; the at-or-after-ptr half
  // is scanned last so it overrides the wrapped half.
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) gnt_idx = PW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (hi_req[i]) gnt_idx = PW'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = any && (gnt_idx == PW'(gi));
    end
  endgenerate

endmodule

// File: rtl/la_ioanalog_arb.sv
// Module: la_ioanalog_arb
// Shares one analog pad cell between NREQ core requesters.  Round-robin
// arbitration, break-before-make dead time, settle delay before grant.
// Optional build macro: LA_IOANALOG_ARB_TIMEOUT_EN (hold timeout + forced release).
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   req         per-requester request level
//   req_path    2 bits per requester: 0=direct, 1=small R, 2=big R, 3=reserved
//   dead_cyc    break cycles (0 behaves as 1)
//   settle_cyc  settle cycles after make (0: grant together with make)
//   hold_max    max grant cycles, 0 = unlimited (timeout build only)
//   grant       one-hot grant, only while the path is settled
//   sw_en       one-hot analog path enable
//   busy        sequencer not idle
//   err_path    sticky: reserved path was arbitrated
//   timeout     one-cycle pulse on forced release (timeout build only)
module la_ioanalog_arb
  import la_ioanalog_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DEADW   = 4,
  parameter int SETTLEW = 8,
  parameter int HOLDW   = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_path,
  input  logic [DEADW-1:0]     dead_cyc,
  input  logic [SETTLEW-1:0]   settle_cyc,
  input  logic [HOLDW-1:0]     hold_max,
  output logic [NREQ-1:0]      grant,
  output logic [2:0]           sw_en,
  output logic                 busy,
  output logic                 err_path,
  output logic                 timeout
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (DEADW > SETTLEW) ? DEADW : SETTLEW;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   win_reg;
  logic [1:0]      path_reg;
  logic [CW-1:0]   cnt_reg;
  logic [NREQ-1:0] grant_reg;
  logic [2:0]      sw_en_reg;
  logic            busy_reg;
  logic            err_reg;

  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] arb_req;
  logic [PW-1:0]   arb_ptr;
  logic [PW-1:0]   ptr_inc;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [1:0]      pick_path;
  logic [CW-1:0]   dead_load;
  logic [CW-1:0]   settle_load;
  logic            win_req;
  logic            enter_active;
  logic            hold_hit;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_win
      assign win_oh[gi] = (win_reg == PW'(gi));
    end
  endgenerate

  assign win_req = req[win_reg];
  assign ptr_inc = (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + 1'b1;

  // Counters hold "cycles remaining minus one"; a zero dead time still
  // gives one break cycle.
  assign dead_load   = (dead_cyc == '0) ? '0 : CW'(dead_cyc - 1'b1);
  assign settle_load = CW'(settle_cyc - 1'b1);

  assign enter_active = win_req && (cnt_reg == '0) &&
                        (((state_reg == BREAK) && (settle_cyc == '0)) ||
                         (state_reg == MAKE));

  // On release the next winner is chosen against the advanced pointer,
  // excluding the outgoing holder (it may still be high after a timeout).
  assign arb_req = (state_reg == ACTIVE) ? (eligible & ~win_oh) : eligible;
  assign arb_ptr = (state_reg == ACTIVE) ? ptr_inc : ptr_reg;

  la_rrarb #(.N(NREQ), .PW(PW)) u_rrarb (
    .req     (arb_req),
    .ptr     (arb_ptr),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    pick_path = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_path = req_path[2*i +: 2];
    end
  end

`ifdef LA_IOANALOG_ARB_TIMEOUT_EN
  logic [HOLDW-1:0] hold_cnt_reg;
  logic             hold_lim_reg;
  logic [NREQ-1:0]  blocked_reg;
  logic             timeout_reg;

  // A req drop wins over a simultaneous expiry: that is an ordinary release.
  assign hold_hit = (state_reg == ACTIVE) && win_req && hold_lim_reg &&
                    (hold_cnt_reg == HOLDW'(1));
  assign eligible = req & ~blocked_reg;
  assign timeout  = timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_reg <= '0;
      hold_lim_reg <= 1'b0;
      blocked_reg  <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= hold_hit;
      // A timed-out requester stays ineligible until it drops req once.
      blocked_reg <= (blocked_reg & req) | (hold_hit ? win_oh : '0);
      if (enter_active) begin
        hold_cnt_reg <= hold_max;
        hold_lim_reg <= |hold_max;
      end else if ((state_reg == ACTIVE) && (hold_cnt_reg > HOLDW'(1))) begin
        hold_cnt_reg <= hold_cnt_reg - 1'b1;
      end
    end
  end
`else
  logic unused_hold;
  assign unused_hold = ^hold_max;
  assign hold_hit    = 1'b0;
  assign eligible    = req;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      path_reg  <= PATH_DIRECT;
      cnt_reg   <= '0;
      grant_reg <= '0;
      sw_en_reg <= '0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          grant_reg <= '0;
          sw_en_reg <= '0;
          if (pick_any) begin
            win_reg   <= pick_idx;
            path_reg  <= pick_path;
            cnt_reg   <= dead_load;
            state_reg <= BREAK;
            busy_reg  <= 1'b1;
            if (pick_path == PATH_RSVD) err_reg <= 1'b1;
          end
        end
        BREAK: begin
          if (!win_req) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == '0) begin
            sw_en_reg <= onehot3(path_reg);
            if (enter_active) begin
              state_reg <= ACTIVE;
              grant_reg <= win_oh;
            end else begin
              state_reg <= MAKE;
              cnt_reg   <= settle_load;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        MAKE: begin
          if (!win_req) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            sw_en_reg <= '0;
          end else if (enter_active) begin
            state_reg <= ACTIVE;
            grant_reg <= win_oh;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ACTIVE: begin
          if (!win_req || hold_hit) begin
            grant_reg <= '0;
            sw_en_reg <= '0;
            ptr_reg   <= ptr_inc;
            if (pick_any) begin
              win_reg   <= pick_idx;
              path_reg  <= pick_path;
              cnt_reg   <= dead_load;
              state_reg <= BREAK;
              if (pick_path == PATH_RSVD) err_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_reg;
  assign sw_en    = sw_en_reg;
  assign busy     = busy_reg;
  assign err_path = err_reg;

endmodule

// File: tb/tb_la_ioanalog_arb.sv
// Testbench for la_ioanalog_arb (NREQ=4).  A transaction-level model plans
// each arbitration round (cyclic order from the rr pointer, grant cycle =
// drive cycle + 1 + max(dead,1) + settle) and queues the expected grants;
// a monitor on the falling edge pops and compares as grants appear.
module tb_la_ioanalog_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_path = '0;
  logic [3:0]  dead_cyc = '0;
  logic [7:0]  settle_cyc = '0;
  logic [11:0] hold_max = '0;
  logic [3:0]  grant;
  logic [2:0]  sw_en;
  logic        busy;
  logic        err_path;
  logic        timeout;

  la_ioanalog_arb dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_path   (req_path),
    .dead_cyc   (dead_cyc),
    .settle_cyc (settle_cyc),
    .hold_max   (hold_max),
    .grant      (grant),
    .sw_en      (sw_en),
    .busy       (busy),
    .err_path   (err_path),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       idx;
    logic [2:0] sw;
    int       make_c;
    int       grant_c;
    int       hold;
    logic     err;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_pass = 0;
  int   n_total = 0;
  int   model_ptr = 0;
  logic model_err = 1'b0;
  int   exp_to_cyc = -1;
  bit   quiet = 1'b0;
  logic [3:0] prev_grant = '0;
  logic [2:0] prev_sw = '0;

  function automatic logic [2:0] path_sw(input int p);
    if (p == 3) return 3'b000;
    return 3'(1 << p);
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && !quiet) begin
      if (sw_en != 3'b000 && prev_sw == 3'b000) begin
        if (q.size() == 0) check("unexpected_make", int'(sw_en), 0);
        else check("make_cycle", cyc, q[0].make_c);
      end
      check("sw_onehot", int'($countones(sw_en) <= 1), 1);
      check("sw_break_before_make",
            int'(prev_sw != 3'b000 && sw_en != 3'b000 && sw_en != prev_sw), 0);
      check("timeout_pulse", int'(timeout), int'(cyc == exp_to_cyc));
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        if (q.size() == 0) begin
          check("unexpected_grant", int'(grant), 0);
        end else begin
          cur = q.pop_front();
          check("grant_id", int'(grant), 1 << cur.idx);
          check("grant_cycle", cyc, cur.grant_c);
          check("grant_sw_en", int'(sw_en), int'(cur.sw));
          check("err_path", int'(err_path), int'(cur.err));
        end
      end else if (grant != 4'b0000) begin
        check("hold_grant", int'(grant), 1 << cur.idx);
        check("hold_sw_en", int'(sw_en), int'(cur.sw));
      end else if (prev_grant != 4'b0000) begin
        check("release_cycle", cyc, cur.grant_c + cur.hold);
        check("release_sw_en", int'(sw_en), 0);
      end
    end
    prev_grant <= grant;
    prev_sw    <= sw_en;
  end

  // One arbitration round: all requesters in 'set' raise req together
  // while the arbiter is idle; each drops req after its hold time.
  task automatic run_round(input logic [3:0] set, input int dv, input int sv,
                           input logic [7:0] pv, input int hlo, input int hhi);
    int order[$];
    int d, t, g, h, idx, last, p;
    exp_t e;
    d = (dv == 0) ? 1 : dv;
    dead_cyc   = 4'(dv);
    settle_cyc = 8'(sv);
    req_path   = pv;
    for (int k = 0; k < 4; k++) begin
      idx = (model_ptr + k) % 4;
      if (set[idx]) order.push_back(idx);
    end
    t = cyc;
    req = set;
    last = 0;
    foreach (order[j]) begin
      idx = order[j];
      p = int'(pv[2*idx +: 2]);
      g = t + 1 + d + sv;
      h = int'($urandom_range(hhi, hlo));
      if (p == 3) model_err = 1'b1;
      e.idx = idx; e.sw = path_sw(p); e.make_c = g - sv;
      e.grant_c = g; e.hold = h; e.err = model_err;
      q.push_back(e);
      $display("txn: req%0d path %0d dead %0d settle %0d hold %0d -> grant at cycle %0d",
               idx, p, dv, sv, h, g);
      if (h > 1) begin
        wait_cyc(g);
        req_path[2*idx +: 2] = 2'($urandom_range(3, 0));
      end
      wait_cyc(g + h - 1);
      req[idx] = 1'b0;
      t = g + h - 1;
      last = idx;
    end
    model_ptr = (last + 1) % 4;
    wait_cyc(t + 1 + int'($urandom_range(3, 0)));
  endtask

  initial begin
    int t;
    logic [3:0] set;
    @(posedge clk); #1;
    wait_cyc(3);
    check("reset_grant", int'(grant), 0);
    check("reset_sw_en", int'(sw_en), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err_path", int'(err_path), 0);
    check("reset_timeout", int'(timeout), 0);
    reset = 1'b0;

    // Single requester, path 1, dead 2, settle 3.
    run_round(4'b0001, 2, 3, 8'h01, 4, 4);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      set = 4'($urandom_range(15, 1));
      run_round(set, int'($urandom_range(4, 0)), int'($urandom_range(5, 0)),
                8'($urandom), 1, 6);
    end

    // Requester drops during BREAK: abort, no switch ever closes.
    dead_cyc = 4'd4; settle_cyc = 8'd2;
    t = cyc;
    req = 4'b0100;
    wait_cyc(t + 1);
    check("abort_busy_high", int'(busy), 1);
    req = 4'b0000;
    wait_cyc(t + 2);
    check("abort_busy_low", int'(busy), 0);
    check("abort_sw_en", int'(sw_en), 0);
    wait_cyc(t + 4);

    // Leaves the rr pointer at 1.
    run_round(4'b0001, 1, 1, 8'h00, 2, 2);

    // Reset during MAKE, then re-arbitrate with all requesters held.
    quiet = 1'b1;
    dead_cyc = 4'd1; settle_cyc = 8'd4; req_path = 8'h55;
    t = cyc;
    req = 4'b1111;
    wait_cyc(t + 3);
    check("pre_reset_sw_en", int'(sw_en), 3'b010);
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    wait_cyc(t + 4);
    check("midreset_sw_en", int'(sw_en), 0);
    check("midreset_grant", int'(grant), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_err_path", int'(err_path), 0);
    reset = 1'b0;
    quiet = 1'b0;
    model_ptr = 0;
    model_err = 1'b0;
    run_round(4'b1111, 2, 3, 8'h55, 5, 5);

`ifdef LA_IOANALOG_ARB_TIMEOUT_EN
    begin
      exp_t e;
      int g0, g1, g2, t2;
      hold_max = 12'd10; dead_cyc = 4'd1; settle_cyc = 8'd2; req_path = 8'h00;
      t = cyc;
      req = 4'b0011;
      g0 = t + 4;
      e.idx = 0; e.sw = 3'b001; e.make_c = g0 - 2; e.grant_c = g0; e.hold = 10; e.err = 1'b0;
      q.push_back(e);
      exp_to_cyc = g0 + 10;
      g1 = g0 + 10 + 1 + 2;
      e.idx = 1; e.make_c = g1 - 2; e.grant_c = g1; e.hold = 4;
      q.push_back(e);
      $display("txn: req0 hold_max 10 -> grant at %0d, timeout at %0d, req1 grant at %0d",
               g0, exp_to_cyc, g1);
      wait_cyc(g1 + 3);
      req[1] = 1'b0;
      wait_cyc(g1 + 12);
      t2 = cyc;
      req[0] = 1'b0;
      wait_cyc(t2 + 1);
      req[0] = 1'b1;
      g2 = t2 + 5;
      e.idx = 0; e.make_c = g2 - 2; e.grant_c = g2; e.hold = 3;
      q.push_back(e);
      $display("txn: req0 toggled -> grant at %0d", g2);
      wait_cyc(g2 + 2);
      req[0] = 1'b0;
      wait_cyc(g2 + 5);
      hold_max = '0;
      model_ptr = 1;
    end
`endif

    wait_cyc(cyc + 10);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
